// File: rtl/reg_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter_pkg
//
// Purpose:
//   Shared constants, helper function and types for the register-sharing
//   round-robin arbiter (reg_share_arbiter) and its grant encoder (rr_grant).
//
// Contents:
//   DEFAULT_N_REQ  - default number of requesters
//   DEFAULT_WIDTH  - default data width per requester
//   id_width(n)    - width needed to hold a requester index for n requesters
//   DEFAULT_ID_W   - index width for the default configuration
//   req_id_t       - requester index type for the default configuration
// ---------------------------------------------------------------------------
package reg_share_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 8;

    // A single requester would give $clog2(1) == 0, which is not a legal
    // vector width, so the index is never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_ID_W = id_width(DEFAULT_N_REQ);

    typedef logic [DEFAULT_ID_W-1:0] req_id_t;

endpackage : reg_share_arbiter_pkg

// File: rtl/reg_share_arbiter_rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
//
// Purpose:
//   Combinational rotate-priority encoder. Starting at index ptr and wrapping
//   past N_REQ-1 back to 0, it reports the first requester whose request bit
//   is set.
//
// Parameters:
//   N_REQ      - number of requesters (2..8)
//   ID_W       - width of a requester index
//
// Ports:
//   req        in   N_REQ  request bits, one per requester
//   ptr        in   ID_W   highest-priority index (must be < N_REQ)
//   grant_idx  out  ID_W   index of the winning requester (0 when none)
//   any        out  1      at least one request bit is set
// ---------------------------------------------------------------------------
module rr_grant
    import reg_share_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    // Walk the requesters in priority order ptr, ptr+1, ... with an explicit
    // modulo-N_REQ wrap, so that non-power-of-two requester counts never
    // wrap through unused index values. The first set bit wins.
    always_comb begin
        int                sum;
        logic [ID_W-1:0]   idx;
        grant_idx = '0;
        any       = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = ID_W'(sum);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule : rr_grant

// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
//
// Purpose:
//   Round-robin arbiter sharing one output register among N_REQ requesters.
//   Each cycle the register can load, one winner is chosen by rotating
//   priority, its data is captured together with its index, and the result
//   is offered downstream over a valid/ready handshake. A granted input
//   appears on the output exactly one cycle after it is accepted.
//
// Parameters:
//   N_REQ  - number of requesters (2..8), default 4
//   WIDTH  - data width per requester, default 8
//   ID_W   - requester index width, derived from N_REQ
//
// Ports:
//   CLK        in   1            clock, rising edge
//   RESET      in   1            synchronous active-high reset
//   req_valid  in   N_REQ        per-requester valid
//   req_data   in   N_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  N_REQ        one-hot-or-zero accept
//   out_valid  out  1            output register holds data
//   out_data   out  WIDTH        registered winner data
//   out_id     out  ID_W         index of the requester that supplied out_data
//   out_ready  in   1            downstream accept
//
// Build option:
//   REG_SHARE_ARBITER_ASSERT_EN - when defined, concurrent assertions on the
//   accept encoding, the one-cycle latency and output stability under
//   backpressure are compiled in. Ports and behaviour do not change.
// ---------------------------------------------------------------------------
module reg_share_arbiter
    import reg_share_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready
);

    // Output register and round-robin pointer, with their next-state values.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]  out_id_q,    out_id_d;
    logic [ID_W-1:0]  ptr_q,       ptr_d;

    logic             loadEn;
    logic [ID_W-1:0]  grantIdx;
    logic             grantAny;
    logic [WIDTH-1:0] dataArr [N_REQ];

    // Unpack the flat data bus so the winner can be selected by index.
    for (genvar i = 0; i < N_REQ; i++) begin : gUnpack
        assign dataArr[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_grant #(
        .N_REQ     (N_REQ),
        .ID_W      (ID_W)
    ) uGrant (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_idx (grantIdx),
        .any       (grantAny)
    );

    // The register may take new data when it is empty or is being drained on
    // this same edge, which is what gives back-to-back transfers with no
    // bubble. Folding RESET in keeps req_ready low throughout reset.
    assign loadEn = !RESET && (!out_valid_q || out_ready);

    // Accept only the current winner, and only when the register can load.
    always_comb begin
        req_ready = '0;
        if (loadEn && grantAny) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    // Next-state logic. A load with no requester empties the register but
    // keeps the last data, index and pointer; a stall holds everything.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (loadEn) begin
            if (grantAny) begin
                out_valid_d = 1'b1;
                out_data_d  = dataArr[grantIdx];
                out_id_d    = grantIdx;
                ptr_d       = (grantIdx == ID_W'(N_REQ - 1)) ? '0
                                                             : grantIdx + ID_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; a reset discards any pending
    // output and restarts the rotation at requester 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef REG_SHARE_ARBITER_ASSERT_EN
    // At most one requester is accepted per cycle.
    aReadyOnehot: assert property (@(posedge CLK) disable iff (RESET)
        $onehot0(req_ready));

    // An accepted request shows up on the output, tagged, one cycle later.
    for (genvar i = 0; i < N_REQ; i++) begin : gAssertLatency
        aLatency: assert property (@(posedge CLK) disable iff (RESET)
            req_valid[i] && req_ready[i] |-> ##1 (out_valid && out_id == ID_W'(i)));
    end

    // Held output stays put while downstream applies backpressure.
    aStableStall: assert property (@(posedge CLK) disable iff (RESET)
        out_valid && !out_ready |-> ##1 (out_valid && $stable(out_data) && $stable(out_id)));
`endif

endmodule : reg_share_arbiter

// File: tb/tb_reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_share_arbiter
//
// Directed bench for reg_share_arbiter with N_REQ=4, WIDTH=8. Inputs are
// driven shortly after a rising edge; the combinational accept is checked
// once inputs settle and registered outputs are checked just after the
// following rising edge. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_reg_share_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   CLK;
    logic                   RESET;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [ID_W-1:0]        out_id;
    logic                   out_ready;

    logic [WIDTH-1:0]       reqDataArr [N_REQ];

    int totalCount;
    int badCount;

    assign req_data = {reqDataArr[3], reqDataArr[2], reqDataArr[1], reqDataArr[0]};

    reg_share_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one set of control inputs and let combinational paths settle.
    task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] valid,
                                 input logic ready);
        RESET     = rst;
        req_valid = valid;
        out_ready = ready;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            reqDataArr[i] = 8'h10 + 8'(i);
        end

        // Reset held for two cycles with every requester asking.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_data",  32'(out_data),  32'h00);
        checkOutput("rst_id",    32'(out_id),    32'h0);

        // Release: full load, grants rotate 0,1,2,3,0,1,2,3 with no bubble.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("full_ready", 32'(req_ready), 32'h1 << (k % 4));
            tick();
            checkOutput("full_valid", 32'(out_valid), 32'h1);
            checkOutput("full_id",    32'(out_id),    32'(k % 4));
            checkOutput("full_data",  32'(out_data),  32'h10 + 32'(k % 4));
        end

        // Single requester 2 while pointer sits at 0; pointer moves to 3.
        reqDataArr[2] = 8'hA5;
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("single_ready", 32'(req_ready), 32'b0100);
        tick();
        checkOutput("single_valid", 32'(out_valid), 32'h1);
        checkOutput("single_data",  32'(out_data),  32'hA5);
        checkOutput("single_id",    32'(out_id),    32'h2);

        // Pointer at 3 with only 0 and 1 asking: skip 3, wrap to 0.
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("wrap_ready0", 32'(req_ready), 32'b0001);
        tick();
        checkOutput("wrap_id0",    32'(out_id),    32'h0);
        checkOutput("wrap_data0",  32'(out_data),  32'h10);
        reqDataArr[1] = 8'h3C;
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("wrap_ready1", 32'(req_ready), 32'b0010);
        tick();
        checkOutput("wrap_id1",    32'(out_id),    32'h1);
        checkOutput("wrap_data1",  32'(out_data),  32'h3C);

        // Backpressure for three cycles: nothing accepted, output frozen.
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("bp_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_ready_hold", 32'(req_ready), 32'h0);
            checkOutput("bp_valid",      32'(out_valid), 32'h1);
            checkOutput("bp_id",         32'(out_id),    32'h1);
            checkOutput("bp_data",       32'(out_data),  32'h3C);
        end
        // Downstream frees up: pointer is 2, so requester 2 wins at once.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("bp_release_ready", 32'(req_ready), 32'b0100);
        tick();
        checkOutput("bp_release_valid", 32'(out_valid), 32'h1);
        checkOutput("bp_release_id",    32'(out_id),    32'h2);
        checkOutput("bp_release_data",  32'(out_data),  32'hA5);

        // Reset mid-operation with a stalled pending output (pointer was 3).
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkOutput("midrst_ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("midrst_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_data",  32'(out_data),  32'h00);
        checkOutput("midrst_id",    32'(out_id),    32'h0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("midrst_first_ready", 32'(req_ready), 32'b0001);
        tick();
        checkOutput("midrst_first_id",    32'(out_id),    32'h0);
        checkOutput("midrst_first_data",  32'(out_data),  32'h10);

        // Idle load: register empties, data/id/pointer hold (pointer = 1).
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("idle_ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("idle_valid", 32'(out_valid), 32'h0);
        checkOutput("idle_id",    32'(out_id),    32'h0);
        checkOutput("idle_data",  32'(out_data),  32'h10);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("idle_ptr_ready", 32'(req_ready), 32'b0010);
        tick();
        checkOutput("idle_ptr_id",    32'(out_id),    32'h1);
        checkOutput("idle_ptr_data",  32'(out_data),  32'h3C);

        // Requester 2 drops valid while stalled and loses its turn to 3.
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("drop_stall_ready", 32'(req_ready), 32'h0);
        applyStimulus(1'b0, 4'b1000, 1'b1);
        checkOutput("drop_ready", 32'(req_ready), 32'b1000);
        tick();
        checkOutput("drop_id",    32'(out_id),    32'h3);
        checkOutput("drop_data",  32'(out_data),  32'h13);
        // Granting 3 wraps the pointer to 0.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("drop_wrap_ready", 32'(req_ready), 32'b0001);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule : tb_reg_share_arbiter
